// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the branch sequencer: jump modes, flag selects, PC mux selects, FSM states.
package branch_sequencer_pkg;

    localparam logic [1:0] MODE_JMP_ABS_REG  = 2'b00;
    localparam logic [1:0] MODE_JMP_REL_HERE = 2'b01;

    localparam logic [1:0] CC_SELECTX_Z = 2'b00;
    localparam logic [1:0] CC_SELECTX_C = 2'b01;
    localparam logic [1:0] CC_SELECTX_P = 2'b10;
    localparam logic [1:0] CC_SELECTX_S = 2'b11;

    localparam logic [1:0] PC_OFFSETX_0   = 2'b00;
    localparam logic [1:0] PC_OFFSETX_2   = 2'b01;
    localparam logic [1:0] PC_OFFSETX_DIN = 2'b10;

    localparam logic [1:0] PC_BASEX_PC_A = 2'b00;
    localparam logic [1:0] PC_BASEX_0    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EVAL     = 2'b01,
        ST_WAIT_DIN = 2'b10,
        ST_LOAD     = 2'b11
    } seq_state_t;

    typedef struct packed {
        logic s;
        logic p;
        logic c;
        logic z;
    } cc_flags_t;

    typedef struct packed {
        logic [1:0] jmpx;
        logic [1:0] cc_selectx;
        logic       cc_invertx;
        logic       cc_applyx;
        cc_flags_t  flags;
    } branch_req_t;

endpackage

// File: rtl/branch_sequencer_logic.sv
// Branch condition evaluation and base-select mapping for a latched branch request.
module branch_sequencer_logic
    import branch_sequencer_pkg::*;
(
    input  branch_req_t i_req,
    output logic        o_taken,
    output logic [1:0]  o_din_basex
);

    logic w_flag;

    always_comb begin
        w_flag = 1'b0;
        case (i_req.cc_selectx)
            CC_SELECTX_Z: w_flag = i_req.flags.z;
            CC_SELECTX_C: w_flag = i_req.flags.c;
            CC_SELECTX_P: w_flag = i_req.flags.p;
            CC_SELECTX_S: w_flag = i_req.flags.s;
            default:      w_flag = 1'b0;
        endcase
    end

    assign o_taken = !i_req.cc_applyx || (w_flag ^ i_req.cc_invertx);

    // Reserved modes fall back to absolute-register addressing.
    assign o_din_basex = (i_req.jmpx == MODE_JMP_REL_HERE) ? PC_BASEX_PC_A : PC_BASEX_0;

endmodule

// File: rtl/branch_sequencer.sv
// PC update sequencer: accepts decoded instructions, evaluates branches, waits for the
// operand word and issues a single PC_LOAD strobe with offset/base selects.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int DIN_TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_instr_valid,
    output logic       o_instr_ready,
    input  logic       i_is_branch,
    input  logic [1:0] i_jmpx,
    input  logic [1:0] i_cc_selectx,
    input  logic       i_cc_invertx,
    input  logic       i_cc_applyx,
    input  logic       i_cc_load,
    input  logic       i_cc_zero,
    input  logic       i_cc_carry,
    input  logic       i_cc_parity,
    input  logic       i_cc_sign,
    input  logic       i_din_valid,
    output logic       o_pc_load,
    output logic [1:0] o_pc_offsetx,
    output logic [1:0] o_pc_basex,
    output logic       o_branch_taken,
    output logic       o_busy,
    output logic       o_fault
);

    localparam logic [7:0] TO_LAST = 8'(DIN_TIMEOUT - 1);

    seq_state_t  r_state, w_next;
    cc_flags_t   r_flags, w_flags_now;
    branch_req_t r_req;
    logic [7:0]  r_cnt;
    logic [1:0]  r_offsetx, r_basex, w_nx_off, w_nx_base;
    logic        r_taken, w_nx_taken;
    logic        r_fault;
    logic        w_latch, w_set_fault, w_cnt_clr, w_cnt_inc;
    logic        w_br_taken;
    logic [1:0]  w_din_basex;

    // Same-cycle CC_LOAD bypasses the snapshot register.
    assign w_flags_now = i_cc_load ? cc_flags_t'{s: i_cc_sign, p: i_cc_parity,
                                                 c: i_cc_carry, z: i_cc_zero}
                                   : r_flags;

    branch_sequencer_logic u_logic (
        .i_req       (r_req),
        .o_taken     (w_br_taken),
        .o_din_basex (w_din_basex)
    );

    always_comb begin
        w_next      = r_state;
        w_nx_off    = r_offsetx;
        w_nx_base   = r_basex;
        w_nx_taken  = r_taken;
        w_latch     = 1'b0;
        w_set_fault = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_instr_valid) begin
                    if (i_is_branch) begin
                        w_latch = 1'b1;
                        w_next  = ST_EVAL;
                    end else begin
                        w_next     = ST_LOAD;
                        w_nx_off   = PC_OFFSETX_2;
                        w_nx_base  = PC_BASEX_PC_A;
                        w_nx_taken = 1'b0;
                    end
                end
            end
            ST_EVAL: begin
                if (w_br_taken) begin
                    w_next    = ST_WAIT_DIN;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_next     = ST_LOAD;
                    w_nx_off   = PC_OFFSETX_2;
                    w_nx_base  = PC_BASEX_PC_A;
                    w_nx_taken = 1'b0;
                end
            end
            ST_WAIT_DIN: begin
                // Operand arriving in the timeout cycle still completes the branch.
                if (i_din_valid) begin
                    w_next     = ST_LOAD;
                    w_nx_off   = PC_OFFSETX_DIN;
                    w_nx_base  = w_din_basex;
                    w_nx_taken = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_next      = ST_LOAD;
                    w_set_fault = 1'b1;
                    w_nx_off    = PC_OFFSETX_2;
                    w_nx_base   = PC_BASEX_PC_A;
                    w_nx_taken  = 1'b0;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_LOAD: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_flags   <= '0;
            r_req     <= '0;
            r_cnt     <= '0;
            r_offsetx <= PC_OFFSETX_0;
            r_basex   <= PC_BASEX_PC_A;
            r_taken   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_offsetx <= w_nx_off;
            r_basex   <= w_nx_base;
            r_taken   <= w_nx_taken;
            if (i_cc_load) begin
                r_flags <= w_flags_now;
            end
            if (w_latch) begin
                r_req <= '{jmpx: i_jmpx, cc_selectx: i_cc_selectx, cc_invertx: i_cc_invertx,
                           cc_applyx: i_cc_applyx, flags: w_flags_now};
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_instr_ready  = (r_state == ST_IDLE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_pc_load      = (r_state == ST_LOAD);
    assign o_pc_offsetx   = r_offsetx;
    assign o_pc_basex     = r_basex;
    assign o_branch_taken = r_taken;
    assign o_fault        = r_fault;

endmodule
